// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the inverse-cipher datapath.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef logic [127:0] aes_state_t;
  typedef logic [31:0]  aes_col_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } imx_state_e;

  // Multiply by 02 in GF(2^8), reduced by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ a;
  endfunction

  function automatic logic [7:0] gf_mulb(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ a;
  endfunction

  function automatic logic [7:0] gf_muld(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ a;
  endfunction

  function automatic logic [7:0] gf_mule(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns for one 32-bit column (row 0 in the MSB byte).
module inv_mix_column
  import aes_pkg::*;
(
  input  aes_col_t col_in,
  output aes_col_t col_out
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  // Circulant inverse matrix {0e, 0b, 0d, 09}.
  always_comb begin
    col_out[31:24] = gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3);
    col_out[23:16] = gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3);
    col_out[15:8]  = gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3);
    col_out[7:0]   = gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3);
  end

endmodule

// File: rtl/inv_mix_state.sv
// Iterative InvMixColumns: accepts a 128-bit state, mixes one column per clock.
module inv_mix_state
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  imx_state_e state_q, state_d;
  aes_state_t st_q, st_d;
  logic [1:0] col_q, col_d;

  aes_col_t   col_sel;
  aes_col_t   col_mix;
  aes_state_t st_wr;

  inv_mix_column u_col (
    .col_in  (col_sel),
    .col_out (col_mix)
  );

  // Select the active column and build the state with it replaced.
  always_comb begin
    st_wr = st_q;
    case (col_q)
      2'd0: begin col_sel = st_q[127:96]; st_wr[127:96] = col_mix; end
      2'd1: begin col_sel = st_q[95:64];  st_wr[95:64]  = col_mix; end
      2'd2: begin col_sel = st_q[63:32];  st_wr[63:32]  = col_mix; end
      default: begin col_sel = st_q[31:0]; st_wr[31:0] = col_mix; end
    endcase
  end

  // Next-state logic and handshake outputs, decoded from the FSM register only.
  always_comb begin
    state_d   = state_q;
    st_d      = st_q;
    col_d     = col_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          st_d    = in_state;
          col_d   = 2'd0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        st_d  = st_wr;
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          state_d = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset; reset clears the working state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      st_q    <= '0;
      col_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      col_q   <= col_d;
    end
  end

  assign out_state = st_q;

endmodule

// File: tb/tb_inv_mix_state.sv
// Scoreboard bench for inv_mix_state: directed cases plus a randomized stream.
module tb_inv_mix_state;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  logic         rand_mode;
  logic         rnd_ready;
  logic         dir_ready;

  int checks;
  int errors;
  logic [127:0] sb_q[$];

  assign out_ready = rand_mode ? rnd_ready : dir_ready;

  inv_mix_state dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plain shift-and-add GF(2^8) multiply.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Circulant column mix over all four columns; coefs holds the first matrix row.
  function automatic logic [127:0] mix_model(input logic [127:0] s, input logic [31:0] coefs);
    logic [127:0] r;
    logic [7:0]   acc;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ gmul(s[127-8*(4*c+j) -: 8], coefs[31-8*((j-row+4)%4) -: 8]);
        end
        r[127-8*(4*c+row) -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a state and hold it until accepted; optionally record the expected result.
  task automatic send(input logic [127:0] s, input logic [127:0] exp, input bit push);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_state = s;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", {127'd0, in_ready}, 128'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (push) sb_q.push_back(exp);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    if (!out_valid) chk("valid_timeout", {127'd0, out_valid}, 128'd1);
  endtask

  // Monitor: every output handshake pops one expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_output: got %h, expected no output", out_state);
      end else begin
        chk("out_state", out_state, sb_q.pop_front());
      end
    end
  end

  // Random output backpressure for the stream phase.
  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    logic [127:0] held;
    logic [127:0] full_in;
    logic [127:0] rs;
    int n;

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_state  = '0;
    dir_ready = 1'b1;
    rand_mode = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_in_ready", {127'd0, in_ready}, 128'd1);
    chk("reset_out_valid", {127'd0, out_valid}, 128'd0);
    chk("reset_out_state", out_state, 128'd0);

    // Single column, with latency check.
    send(128'h8e4da1bc_00000000_00000000_00000000,
         128'hdb135345_00000000_00000000_00000000, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("latency_e%0d", k), {127'd0, out_valid}, {127'd0, (k == 4)});
    end
    tick();

    // Full state including fixed-point columns, plus forward-mix round trip.
    full_in = 128'h9fdc589d_c6c6c6c6_01010101_d5d5d7d6;
    send(full_in, 128'hf20a225c_c6c6c6c6_01010101_d4d4d4d5, 1'b1);
    wait_valid();
    chk("fwd_identity", mix_model(out_state, 32'h02030101), full_in);
    tick();

    // Backpressure: hold the result in DONE for 10 cycles.
    dir_ready = 1'b0;
    rs = {$urandom, $urandom, $urandom, $urandom};
    send(rs, mix_model(rs, 32'h0e0b0d09), 1'b1);
    wait_valid();
    held = out_state;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_valid", {127'd0, out_valid}, 128'd1);
      chk("bp_stable", out_state, held);
      chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
    end
    dir_ready = 1'b1;
    tick();
    chk("bp_release_in_ready", {127'd0, in_ready}, 128'd1);
    chk("bp_release_valid", {127'd0, out_valid}, 128'd0);

    // New input offered while BUSY must be ignored.
    rs = 128'h00112233_44556677_8899aabb_ccddeeff;
    send(rs, mix_model(rs, 32'h0e0b0d09), 1'b1);
    in_valid = 1'b1;
    in_state = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
    repeat (3) tick();
    in_valid = 1'b0;
    repeat (8) tick();
    chk("ignored_single_output", {96'd0, sb_q.size()}, 128'd0);

    // Reset in BUSY with col_q == 2 discards the block.
    send(128'h01020304_05060708_090a0b0c_0d0e0f10, '0, 1'b0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", {127'd0, in_ready}, 128'd1);
    chk("abort_out_valid", {127'd0, out_valid}, 128'd0);
    chk("abort_out_state", out_state, 128'd0);
    repeat (8) tick();

    // Random stream with input gaps and output backpressure.
    rand_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      rs = {$urandom, $urandom, $urandom, $urandom};
      send(rs, mix_model(rs, 32'h0e0b0d09), 1'b1);
    end
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    rand_mode = 1'b0;
    repeat (4) tick();
    chk("stream_drained", {96'd0, sb_q.size()}, 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
